link_ddr_upstream_ch: RTL and testbench

LINK_DDR_UPSTREAM_CH -- requirements
Module: link_ddr_upstream_ch

---
 rtl/link_ddr_upstream_ch_pkg.sv | 16 +
 rtl/link_fifo_sync.sv | 46 ++++
 rtl/link_ddr_upstream_ch.sv | 132 +++++++++++++
 tb/tb_link_ddr_upstream_ch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_ddr_upstream_ch_pkg.sv
// Shared definitions for the DDR link channel pair (upstream serializer and
// the downstream channel model): FSM state encoding and default geometry.
package link_ddr_upstream_ch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } link_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_CHANNEL_W   = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_CREDITS     = 8;
  localparam int DEF_TOKEN_DECIM = 2;

endpackage

// File: rtl/link_fifo_sync.sv
// Synchronous show-ahead FIFO; pointers carry one wrap bit so full/empty are
// decided from registered pointers only.
module link_fifo_sync #(
  parameter int WIDTH_P = 32,
  parameter int DEPTH_P = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [WIDTH_P-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [WIDTH_P-1:0] rd_data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH_P);

  logic [WIDTH_P-1:0] mem_q [DEPTH_P];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               do_wr, do_rd;

  always_comb begin
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o   = (wr_ptr_q == rd_ptr_q);
    // A read in the same cycle as a blocked write frees the slot only next cycle.
    do_wr     = wr_en_i && !full_o;
    do_rd     = rd_en_i && !empty_o;
    wr_ptr_d  = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/link_ddr_upstream_ch.sv
// Upstream DDR link channel: buffers core words, serializes them LSB beat
// first onto the io channel, and gates each word on downstream token credits.
module link_ddr_upstream_ch
  import link_ddr_upstream_ch_pkg::*;
#(
  parameter int WIDTH_P       = DEF_WIDTH,
  parameter int CHANNEL_W_P   = DEF_CHANNEL_W,
  parameter int FIFO_DEPTH_P  = DEF_FIFO_DEPTH,
  parameter int CREDITS_P     = DEF_CREDITS,
  parameter int TOKEN_DECIM_P = DEF_TOKEN_DECIM
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH_P-1:0]           core_data_i,
  input  logic                         core_valid_i,
  output logic                         core_ready_o,
  output logic [CHANNEL_W_P-1:0]       io_data_o,
  output logic                         io_valid_o,
  input  logic                         io_token_i,
  output logic [$clog2(CREDITS_P):0]   credit_o,
  output logic                         overflow_o,
  output link_state_e                  dbg_state_o
);

  localparam int BEATS  = WIDTH_P / CHANNEL_W_P;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CRED_W = $clog2(CREDITS_P) + 1;
  localparam int SUM_W  = $clog2(CREDITS_P + TOKEN_DECIM_P + 1) + 1;

  link_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_P-1:0]     shift_q, shift_d;
  logic [CHANNEL_W_P-1:0] io_data_q, io_data_d;
  logic                   io_valid_q, io_valid_d;
  logic [CRED_W-1:0]      credit_q, credit_d;
  logic                   overflow_q, overflow_d;
  logic                   token_q, token_d;

  logic [WIDTH_P-1:0]     head;
  logic                   fifo_full, fifo_empty;
  logic                   tok_edge, last_beat, start;
  logic [SUM_W-1:0]       credit_sum;

  link_fifo_sync #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (FIFO_DEPTH_P)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (core_valid_i),
    .wr_data_i (core_data_i),
    .rd_en_i   (start),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    tok_edge  = io_token_i && !token_q;
    token_d   = io_token_i;
    last_beat = (state_q == ST_SEND) && (cnt_q == CNT_W'(BEATS - 1));
    // Back-to-back reload may spend a credit returned in this same cycle.
    start     = !fifo_empty &&
                (((state_q == ST_IDLE) && (credit_q != '0)) ||
                 (last_beat && ((credit_q != '0) || tok_edge)));

    credit_sum = SUM_W'(credit_q)
               + (tok_edge ? SUM_W'(TOKEN_DECIM_P) : '0)
               - (start ? SUM_W'(1) : '0);
    overflow_d = overflow_q;
    if (credit_sum > SUM_W'(CREDITS_P)) begin
      credit_d   = CRED_W'(CREDITS_P);
      overflow_d = 1'b1;
    end else begin
      credit_d   = credit_sum[CRED_W-1:0];
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    io_data_d  = io_data_q;
    io_valid_d = io_valid_q;
    if (start) begin
      state_d    = ST_SEND;
      cnt_d      = '0;
      io_data_d  = head[CHANNEL_W_P-1:0];
      shift_d    = head >> CHANNEL_W_P;
      io_valid_d = 1'b1;
    end else if (state_q == ST_SEND) begin
      if (last_beat) begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        io_data_d  = '0;
        io_valid_d = 1'b0;
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        io_data_d  = shift_q[CHANNEL_W_P-1:0];
        shift_d    = shift_q >> CHANNEL_W_P;
      end
    end

    core_ready_o = !fifo_full;
    io_data_o    = io_data_q;
    io_valid_o   = io_valid_q;
    credit_o     = credit_q;
    overflow_o   = overflow_q;
    dbg_state_o  = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      io_data_q  <= '0;
      io_valid_q <= 1'b0;
      credit_q   <= CRED_W'(CREDITS_P);
      overflow_q <= 1'b0;
      token_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      token_q    <= token_d;
    end
  end

endmodule

// File: tb/tb_link_ddr_upstream_ch.sv
// Bench for link_ddr_upstream_ch: directed scenarios plus a randomized round,
// with a beat scoreboard and an arithmetic credit model.
module tb_link_ddr_upstream_ch;
  import link_ddr_upstream_ch_pkg::*;

  localparam int W     = 32;
  localparam int CW    = 8;
  localparam int BEATS = W / CW;
  localparam int CRED  = 8;
  localparam int DECIM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  core_data = '0;
  logic          core_valid = 1'b0;
  logic          core_ready;
  logic [CW-1:0] io_data;
  logic          io_valid;
  logic          io_token = 1'b0;
  logic [3:0]    credit;
  logic          overflow;
  link_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected beats in transmit order.
  logic [CW-1:0] exp_q[$];
  int beat_idx = 0;
  int run = 0;
  int last_run = 0;
  logic prev_valid = 1'b0;

  link_ddr_upstream_ch dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_i  (core_data),
    .core_valid_i (core_valid),
    .core_ready_o (core_ready),
    .io_data_o    (io_data),
    .io_valid_o   (io_valid),
    .io_token_i   (io_token),
    .credit_o     (credit),
    .overflow_o   (overflow),
    .dbg_state_o  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_credit(input int c);
    return (c > CRED) ? CRED : c;
  endfunction

  // Beat monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (io_valid) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat_data", io_data, exp_q.pop_front());
        if (beat_idx != 0) check("beat_contig", prev_valid, 1);
        beat_idx = (beat_idx + 1) % BEATS;
        run++;
      end else begin
        check("idle_data", io_data, 0);
        if (run != 0) last_run = run;
        run = 0;
      end
      prev_valid = io_valid;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_valid = 1'b0;
    io_token = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    beat_idx = 0;
    run = 0;
    last_run = 0;
    prev_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] data, output bit ok);
    ok = 1'b0;
    core_valid = 1'b1;
    core_data = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (core_ready) begin
        @(posedge clk);
        for (int k = 0; k < BEATS; k++) exp_q.push_back(data[k*CW +: CW]);
        ok = 1'b1;
        break;
      end
    end
    #1;
    core_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic token_pulse();
    io_token = 1'b1;
    tick();
    io_token = 1'b0;
    tick();
  endtask

  task automatic wait_quiet();
    int idle = 0;
    for (int i = 0; i < 400 && idle < 4; i++) begin
      @(negedge clk);
      idle = io_valid ? 0 : idle + 1;
    end
    check("quiet_timeout", idle >= 4, 1);
    tick();
  endtask

  logic [W-1:0] words [9];
  bit ok;
  int seen;
  int n_words;
  int n_tok;
  int exp_credit;

  initial begin
    // Single word: reset state, latency, beat order
    do_reset();
    @(negedge clk);
    check("rst_credit", credit, CRED);
    check("rst_ready", core_ready, 1);
    check("rst_valid", io_valid, 0);
    check("rst_data", io_data, 0);
    check("rst_overflow", overflow, 0);
    tick();
    push(32'hDDCCBBAA, ok);
    @(negedge clk);
    check("lat_t1_valid", io_valid, 0);
    @(negedge clk); check("lat_b0", {io_valid, io_data}, {1'b1, 8'hAA});
    @(negedge clk); check("lat_b1", {io_valid, io_data}, {1'b1, 8'hBB});
    @(negedge clk); check("lat_b2", {io_valid, io_data}, {1'b1, 8'hCC});
    @(negedge clk); check("lat_b3", {io_valid, io_data}, {1'b1, 8'hDD});
    @(negedge clk);
    check("lat_end_valid", io_valid, 0);
    check("single_credit", credit, CRED - 1);

    // Nine words, no tokens: eight stream contiguously, ninth waits
    do_reset();
    for (int i = 0; i < 9; i++) begin
      words[i] = $urandom;
      push(words[i], ok);
    end
    wait_quiet();
    check("b2b_run", last_run, 32);
    check("b2b_credit0", credit, 0);
    check("b2b_ninth_held", exp_q.size(), BEATS);
    io_token = 1'b1;
    tick();
    io_token = 1'b0;
    seen = 0;
    for (int k = 1; k <= 4 && seen == 0; k++) begin
      @(negedge clk);
      if (io_valid) seen = k;
    end
    check("token_start_in_2", (seen >= 1) && (seen <= 2), 1);
    wait_quiet();
    check("ninth_credit", credit, 1);
    check("ninth_drained", exp_q.size(), 0);

    // FIFO fill with zero credit
    push($urandom, ok);
    wait_quiet();
    check("fill_credit0", credit, 0);
    for (int i = 0; i < 4; i++) push($urandom, ok);
    @(negedge clk);
    check("fill_ready_low", core_ready, 0);
    words[0] = $urandom;
    core_valid = 1'b1;
    core_data = words[0];
    repeat (3) @(negedge clk);
    check("fill_held", core_ready, 0);
    #1;
    io_token = 1'b1;
    tick();
    io_token = 1'b0;
    push(words[0], ok);
    check("fill_fifth_accepted", ok, 1);
    token_pulse();
    token_pulse();
    wait_quiet();
    check("fill_drained", exp_q.size(), 0);
    check("fill_credit", credit, 1);

    // Token edge on the same cycle as a start at credit 1
    do_reset();
    for (int i = 0; i < 7; i++) push($urandom, ok);
    wait_quiet();
    check("pre_credit1", credit, 1);
    push($urandom, ok);
    io_token = 1'b1;
    tick();
    io_token = 1'b0;
    @(negedge clk);
    check("same_cycle_credit", credit, 2);
    wait_quiet();
    check("same_cycle_final", credit, 2);

    // Overflow at full credit
    do_reset();
    repeat (5) token_pulse();
    @(negedge clk);
    check("ovf_credit", credit, CRED);
    check("ovf_set", overflow, 1);
    repeat (5) tick();
    @(negedge clk);
    check("ovf_sticky", overflow, 1);
    tick();
    do_reset();
    @(negedge clk);
    check("ovf_cleared", overflow, 0);

    // Reset during beat 2
    tick();
    push(32'h44332211, ok);
    repeat (3) tick();
    do_reset();
    @(negedge clk);
    check("midrst_valid", io_valid, 0);
    check("midrst_credit", credit, CRED);
    check("midrst_ready", core_ready, 1);
    wait_quiet();
    check("midrst_no_beats", exp_q.size(), 0);

    // Randomized round: data via scoreboard, credits via arithmetic model
    do_reset();
    n_words = $urandom_range(3, 6);
    for (int i = 0; i < n_words; i++) begin
      push($urandom, ok);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_quiet();
    check("rnd_drained", exp_q.size(), 0);
    exp_credit = CRED - n_words;
    check("rnd_credit", credit, exp_credit);
    n_tok = n_words / 2;
    repeat (n_tok) token_pulse();
    exp_credit = sat_credit(exp_credit + DECIM * n_tok);
    @(negedge clk);
    check("rnd_credit_ret", credit, exp_credit);
    check("rnd_no_ovf", overflow, 0);
    n_tok = $urandom_range(1, 4);
    repeat (n_tok) token_pulse();
    @(negedge clk);
    check("rnd_credit_sat", credit, sat_credit(exp_credit + DECIM * n_tok));
    check("rnd_ovf", overflow, (exp_credit + DECIM * n_tok) > CRED);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
